seg7_scan_driver: RTL and testbench

Time-multiplexed six-digit seven-segment display driver for the chess clock. It consumes the six BCD digits produced by the countdown clock (h2 h1 : m2 m1 : s2 s1). It scans them one digit at a time onto a shared segment bus with per-digit anode enables. Digits are snapshotted once per frame to prevent tearing, and a guard interval between digits prevents ghosting.

---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Display-side bundle for the six-digit scan driver.
//   en                 display enable (low = dark)
//   s1,s2,m1,m2,h1,h2  BCD digits from the countdown clock
//   seg                segments {g,f,e,d,c,b,a}
//   dp                 decimal point (hh.mm.ss separator)
//   an                 anode enables, bit 0 = s1 ... bit 5 = h2
//   frame_done         one-cycle pulse on the last cycle of each frame
// master: the digit source / observer; slave: the scan driver.
interface seg7_scan_driver_if;
    logic       en;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    modport master (output en, s1, s2, m1, m2, h1, h2,
                    input  seg, dp, an, frame_done);
    modport slave  (input  en, s1, s2, m1, m2, h1, h2,
                    output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed six-digit seven-segment driver. Digits are snapshotted
//   once per frame; each digit slot starts with BLANK_CYCLES of all anodes
//   off to stop ghosting, then shows the digit for the rest of the slot.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (wins over en)
//   bus   seg7_scan_driver_if.slave (en, digits in; seg/dp/an/frame_done out)
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, a zero h2 is shown dark, and h1 too when both hour digits
//   are zero. Anode timing and dp are unaffected.
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES   = 125000,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_driver_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int             CW        = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [5:0]     AN_OFF    = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
    // With no blank interval a slot opens directly in SHOW.
    localparam state_t         SLOT_FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t        state, state_n;
    logic [2:0]    slot, slot_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [23:0]   snap, snap_n, live;
    logic [6:0]    seg_q, seg_n;
    logic          dp_q, dp_n;
    logic [5:0]    an_q, an_n;
    logic          fd_q, fd_n;
    logic [3:0]    digit_n;
    logic [6:0]    seg_raw;
    logic          show_n;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: dec7 = 7'h3F;
            4'd1: dec7 = 7'h06;
            4'd2: dec7 = 7'h5B;
            4'd3: dec7 = 7'h4F;
            4'd4: dec7 = 7'h66;
            4'd5: dec7 = 7'h6D;
            4'd6: dec7 = 7'h7D;
            4'd7: dec7 = 7'h07;
            4'd8: dec7 = 7'h7F;
            4'd9: dec7 = 7'h6F;
            default: dec7 = 7'h40;  // non-BCD: dash
        endcase
    endfunction

    // Packed in slot order so slot n is nibble n.
    assign live = {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot  <= 3'd0;
            cnt   <= '0;
            snap  <= 24'd0;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
            fd_q  <= 1'b0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            cnt   <= cnt_n;
            snap  <= snap_n;
            seg_q <= seg_n;
            dp_q  <= dp_n;
            an_q  <= an_n;
            fd_q  <= fd_n;
        end
    end

    // Outputs are decoded from the next-state values and registered, so
    // they line up exactly with the state they describe.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        cnt_n   = cnt;
        snap_n  = snap;
        if (!bus.en) begin
            state_n = IDLE;
            slot_n  = 3'd0;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            state_n = SLOT_FIRST;
            slot_n  = 3'd0;
            cnt_n   = '0;
            snap_n  = live;
        end else if (cnt == CNT_LAST) begin
            state_n = SLOT_FIRST;
            cnt_n   = '0;
            if (slot == 3'd5) begin
                slot_n = 3'd0;
                snap_n = live;
            end else begin
                slot_n = slot + 3'd1;
            end
        end else begin
            cnt_n   = cnt + 1'b1;
            state_n = (cnt_n >= CNT_BLANK) ? SHOW : BLANK;
        end

        digit_n = snap_n[{slot_n, 2'b00} +: 4];
        seg_raw = dec7(digit_n);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot_n == 3'd5 && snap_n[23:20] == 4'd0)
            seg_raw = 7'h00;
        if (slot_n == 3'd4 && snap_n[23:20] == 4'd0 && snap_n[19:16] == 4'd0)
            seg_raw = 7'h00;
`endif
        show_n = (state_n == SHOW);
        seg_n  = show_n ? seg_raw : 7'h00;
        dp_n   = show_n && (slot_n == 3'd2 || slot_n == 3'd4);
        an_n   = show_n ? (6'd1 << slot_n) : 6'd0;
        fd_n   = (state_n != IDLE) && (slot_n == 3'd5) && (cnt_n == CNT_LAST);

        if (SEG_ACTIVE_LOW) begin
            seg_n = ~seg_n;
            dp_n  = ~dp_n;
        end
        if (AN_ACTIVE_LOW)
            an_n = ~an_n;
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with DIGIT_CYCLES=10, BLANK_CYCLES=2,
//   active-low segments and anodes. A cycle-position model (t = clocks since
//   slot 0 started) plus decode/slot tables give every expected value.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIGIT_CYCLES   (10),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // d[0] = s1 ... d[5] = h2
    logic [3:0] d [6];
    assign bus.s1 = d[0];
    assign bus.s2 = d[1];
    assign bus.m1 = d[2];
    assign bus.m2 = d[3];
    assign bus.h1 = d[4];
    assign bus.h2 = d[5];

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;    // expected active-low segment pattern
    } dec_vec_t;

    typedef struct {
        logic [5:0] an;     // expected active-low anode pattern in SHOW
        logic       dp;     // expected active-low dp in SHOW
    } slot_vec_t;

    dec_vec_t  dec_tab  [16];
    slot_vec_t slot_tab [6];

    int         checks = 0;
    int         errors = 0;
    int         t      = 0;
    bit         run    = 1'b0;
    logic [3:0] snap [6];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h, expected %h", nm, t, act, exp);
        end
    endtask

    task automatic check_cycle();
        int         slot;
        int         p;
        logic [5:0] ean;
        logic [6:0] eseg;
        slot = (t / 10) % 6;
        p    = t % 10;
        ean  = (p >= 2) ? slot_tab[slot].an : 6'h3F;
        chk("an", {2'b00, bus.an}, {2'b00, ean});
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, (t % 60 == 59)});
        if (p >= 2) begin
            eseg = dec_tab[snap[slot]].seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (slot == 5 && snap[5] == 4'd0) eseg = 7'h7F;
            if (slot == 4 && snap[5] == 4'd0 && snap[4] == 4'd0) eseg = 7'h7F;
`endif
            chk("seg", {1'b0, bus.seg}, {1'b0, eseg});
            chk("dp", {7'd0, bus.dp}, {7'd0, slot_tab[slot].dp});
        end
    endtask

    task automatic check_off(input string nm);
        chk({nm, "_an"},  {2'b00, bus.an},  8'h3F);
        chk({nm, "_seg"}, {1'b0, bus.seg},  8'h7F);
        chk({nm, "_dp"},  {7'd0, bus.dp},   8'h01);
        chk({nm, "_fd"},  {7'd0, bus.frame_done}, 8'h00);
    endtask

    // Edge that samples en=1 while idle: slot 0 starts here.
    task automatic enter();
        for (int i = 0; i < 6; i++) snap[i] = d[i];
        @(posedge clk); #1;
        t   = 0;
        run = 1'b1;
        check_cycle();
    endtask

    task automatic step();
        if (run) begin
            t++;
            if (t % 60 == 0)
                for (int i = 0; i < 6; i++) snap[i] = d[i];
        end
        @(posedge clk); #1;
        if (run) check_cycle();
    endtask

    initial begin
        dec_tab[0]  = '{4'h0, 7'h40};  dec_tab[1]  = '{4'h1, 7'h79};
        dec_tab[2]  = '{4'h2, 7'h24};  dec_tab[3]  = '{4'h3, 7'h30};
        dec_tab[4]  = '{4'h4, 7'h19};  dec_tab[5]  = '{4'h5, 7'h12};
        dec_tab[6]  = '{4'h6, 7'h02};  dec_tab[7]  = '{4'h7, 7'h78};
        dec_tab[8]  = '{4'h8, 7'h00};  dec_tab[9]  = '{4'h9, 7'h10};
        dec_tab[10] = '{4'hA, 7'h3F};  dec_tab[11] = '{4'hB, 7'h3F};
        dec_tab[12] = '{4'hC, 7'h3F};  dec_tab[13] = '{4'hD, 7'h3F};
        dec_tab[14] = '{4'hE, 7'h3F};  dec_tab[15] = '{4'hF, 7'h3F};
        slot_tab[0] = '{6'h3E, 1'b1};
        slot_tab[1] = '{6'h3D, 1'b1};
        slot_tab[2] = '{6'h3B, 1'b0};
        slot_tab[3] = '{6'h37, 1'b1};
        slot_tab[4] = '{6'h2F, 1'b0};
        slot_tab[5] = '{6'h1F, 1'b1};

        // h2..s1 = 0,1,2,3,4,5
        d[5] = 4'd0; d[4] = 4'd1; d[3] = 4'd2;
        d[2] = 4'd3; d[1] = 4'd4; d[0] = 4'd5;
        rst    = 1'b1;
        bus.en = 1'b1;

        // Reset held 3 cycles with en high: everything stays dark.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_off("reset");
        end
        rst = 1'b0;

        enter();
        step();
        step();
        chk("startup_an", {2'b00, bus.an}, 8'h3E);

        // s1 changes mid-frame twice; each value appears only a frame later.
        while (t < 65) step();
        d[0] = 4'd9;
        while (t < 130) step();
        d[0] = 4'hC;
        while (t < 214) step();   // frame 3, slot 3 in SHOW

        bus.en = 1'b0;
        run    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_off("en_low");
        end

        // Restart with hours 00 and minutes 12.
        d[5] = 4'd0; d[4] = 4'd0; d[3] = 4'd1; d[2] = 4'd2;
        bus.en = 1'b1;
        enter();
        chk("restart_blank0", {2'b00, bus.an}, 8'h3F);
        step();
        chk("restart_blank1", {2'b00, bus.an}, 8'h3F);
        step();
        chk("restart_an", {2'b00, bus.an}, 8'h3E);
        while (t < 65) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
